// File: rtl/dtt_xbar_pkg.sv
// Shared definitions for the valid/ready crossbar switch.
// Contents: default parameter values, a beat struct {data, last},
// the per-output packet lock state, and a destination-width helper.
package dtt_xbar_pkg;

  localparam int DEFAULT_N_IN       = 4;
  localparam int DEFAULT_N_OUT      = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          last;
  } beat_t;

  // IDLE: output free for arbitration; HELD: output owned by one input until in_last
  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  // Destination field needs at least one bit even for a single output
  function automatic int dest_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/dtt_rr_arbiter.sv
// Round-robin arbiter with a stored priority pointer.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (pointer -> 0)
//   req[N]       - request vector
//   advance      - a grant was consumed; move pointer past advance_idx
//   advance_idx  - index of the consumed grant
//   grant[N]     - one-hot grant, search starts at the pointer and wraps
module dtt_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N-1:0]                        req,
  input  logic                                advance,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] advance_idx,
  output logic [N-1:0]                        grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic          found;
  int            cand;

  // Pick the first requester at or after the pointer, wrapping modulo N
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand[IW-1:0]]) begin
        grant[cand[IW-1:0]] = 1'b1;
        found               = 1'b1;
      end else begin
      end
    end
  end

  // Pointer moves one past the consumed grant; stalls and idle cycles leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (advance_idx == IW'(N - 1)) ? '0 : advance_idx + IW'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/dtt_crossbar_arb_switch.sv
// Registered N_IN x N_OUT crossbar, valid/ready on every port, one
// round-robin arbiter per output, source tag on every output beat.
// Optional packet lock: define DTT_XBAR_PKT_LOCK_EN to keep an output
// owned by one input from its first beat until the in_last beat.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_data/in_dest/in_last   - per-input beat payload, target, end marker
//   in_valid / in_ready       - input handshake (in_ready combinational)
//   out_data/out_src/out_last - registered beat, source index, end marker
//   out_valid / out_ready     - output handshake
module dtt_crossbar_arb_switch
  import dtt_xbar_pkg::*;
#(
  parameter int N_IN       = DEFAULT_N_IN,
  parameter int N_OUT      = DEFAULT_N_OUT,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEST_WIDTH = dest_width(N_OUT),
  parameter int SRC_WIDTH  = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data  [N_IN],
  input  logic [DEST_WIDTH-1:0] in_dest  [N_IN],
  input  logic [N_IN-1:0]       in_last,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [DATA_WIDTH-1:0] out_data [N_OUT],
  output logic [SRC_WIDTH-1:0]  out_src  [N_OUT],
  output logic [N_OUT-1:0]      out_last,
  output logic [N_OUT-1:0]      out_valid,
  input  logic [N_OUT-1:0]      out_ready
);

  logic [N_OUT-1:0][N_IN-1:0] grant_all;
  logic [N_IN-1:0]            bad_dest;

  // A valid beat aimed past the last output is swallowed
  always_comb begin
    bad_dest = '0;
    for (int i = 0; i < N_IN; i++) begin
      bad_dest[i] = in_valid[i] && ({1'b0, in_dest[i]} >= (DEST_WIDTH + 1)'(N_OUT));
    end
  end

  // An input is ready when some output granted it or its beat is being discarded
  always_comb begin
    in_ready = bad_dest;
    for (int i = 0; i < N_IN; i++) begin
      for (int j = 0; j < N_OUT; j++) begin
        in_ready[i] = in_ready[i] | grant_all[j][i];
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    logic [N_IN-1:0]       req;
    logic [N_IN-1:0]       grant;
    logic [SRC_WIDTH-1:0]  gidx;
    logic                  can_load;
    logic                  xfer;
    logic                  adv;
    logic                  valid_r;
    logic                  last_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [SRC_WIDTH-1:0]  src_r;

    assign can_load = ~valid_r | out_ready[j];

`ifdef DTT_XBAR_PKT_LOCK_EN
    lock_state_t          lock_state;
    logic [SRC_WIDTH-1:0] lock_src;

    // Requests for this output; while locked only the owning input may compete
    always_comb begin
      req = '0;
      for (int i = 0; i < N_IN; i++) begin
        req[i] = can_load && in_valid[i] && (in_dest[i] == DEST_WIDTH'(j)) &&
                 ((lock_state == LOCK_IDLE) || (lock_src == SRC_WIDTH'(i)));
      end
    end

    // Pointer stays put for the whole packet and moves only on its last beat
    assign adv = xfer & in_last[gidx];

    // Lock tracking: a non-last beat claims the output, a last beat releases it
    always_ff @(posedge clk) begin
      if (rst) begin
        lock_state <= LOCK_IDLE;
        lock_src   <= '0;
      end else if (xfer) begin
        if (in_last[gidx]) begin
          lock_state <= LOCK_IDLE;
          lock_src   <= lock_src;
        end else begin
          lock_state <= LOCK_HELD;
          lock_src   <= gidx;
        end
      end else begin
        lock_state <= lock_state;
        lock_src   <= lock_src;
      end
    end
`else
    // Requests for this output, only when its register can take a beat
    always_comb begin
      req = '0;
      for (int i = 0; i < N_IN; i++) begin
        req[i] = can_load && in_valid[i] && (in_dest[i] == DEST_WIDTH'(j));
      end
    end

    assign adv = xfer;
`endif

    dtt_rr_arbiter #(
      .N (N_IN)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .advance     (adv),
      .advance_idx (gidx),
      .grant       (grant)
    );

    // One-hot grant to input index
    always_comb begin
      gidx = '0;
      for (int i = 0; i < N_IN; i++) begin
        if (grant[i]) begin
          gidx = SRC_WIDTH'(i);
        end else begin
        end
      end
    end

    assign xfer         = |grant;
    assign grant_all[j] = grant;

    // Output register: load on grant, drain on ready, otherwise hold
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        data_r  <= '0;
        src_r   <= '0;
        last_r  <= 1'b0;
      end else if (xfer) begin
        valid_r <= 1'b1;
        data_r  <= in_data[gidx];
        src_r   <= gidx;
        last_r  <= in_last[gidx];
      end else if (out_ready[j]) begin
        valid_r <= 1'b0;
        data_r  <= data_r;
        src_r   <= src_r;
        last_r  <= last_r;
      end else begin
        valid_r <= valid_r;
        data_r  <= data_r;
        src_r   <= src_r;
        last_r  <= last_r;
      end
    end

    assign out_valid[j] = valid_r;
    assign out_data[j]  = data_r;
    assign out_src[j]   = src_r;
    assign out_last[j]  = last_r;
  end

endmodule

// File: tb/tb_dtt_crossbar_arb_switch.sv
// Self-checking bench for dtt_crossbar_arb_switch (4 inputs, 3 outputs so
// destination 3 is out of range). A behavioural model predicts in_ready and
// the output registers every cycle; directed sections pin literal values.
module tb_dtt_crossbar_arb_switch;

  localparam int NI  = 4;
  localparam int NO  = 3;
  localparam int DW  = 32;
  localparam int DSW = 2;
  localparam int SW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] in_data  [NI];
  logic [DSW-1:0] in_dest [NI];
  logic [NI-1:0] in_last;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [DW-1:0] out_data [NO];
  logic [SW-1:0] out_src  [NO];
  logic [NO-1:0] out_last;
  logic [NO-1:0] out_valid;
  logic [NO-1:0] out_ready;

  dtt_crossbar_arb_switch #(
    .N_IN       (NI),
    .N_OUT      (NO),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int checks = 0;
  int passes = 0;

  // Behavioural model state
  int            m_ptr  [NO];
  logic [NO-1:0] m_valid;
  logic [DW-1:0] m_data [NO];
  int            m_src  [NO];
  logic [NO-1:0] m_last;
  bit            m_lock [NO];
  int            m_owner[NO];
  int            m_gnt  [NO];
  logic [NI-1:0] m_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Decide, from the rules, which input each output takes this cycle
  task automatic model_arb();
    m_ready = '0;
    for (int j = 0; j < NO; j++) begin
      m_gnt[j] = -1;
      if (!m_valid[j] || out_ready[j]) begin
        for (int off = 0; off < NI; off++) begin
          int c;
          c = (m_ptr[j] + off) % NI;
`ifdef DTT_XBAR_PKT_LOCK_EN
          if (m_lock[j] && c != m_owner[j]) continue;
`endif
          if (m_gnt[j] < 0 && in_valid[c] && int'(in_dest[c]) == j) m_gnt[j] = c;
        end
      end
      if (m_gnt[j] >= 0) m_ready[m_gnt[j]] = 1'b1;
    end
    for (int i = 0; i < NI; i++)
      if (in_valid[i] && int'(in_dest[i]) >= NO) m_ready[i] = 1'b1;
  endtask

  // Apply the clock edge to the model
  task automatic model_edge();
    for (int j = 0; j < NO; j++) begin
      if (rst) begin
        m_ptr[j] = 0; m_valid[j] = 1'b0; m_data[j] = '0; m_src[j] = 0;
        m_last[j] = 1'b0; m_lock[j] = 1'b0; m_owner[j] = 0;
      end else if (m_gnt[j] >= 0) begin
        int g;
        g = m_gnt[j];
        m_valid[j] = 1'b1; m_data[j] = in_data[g]; m_src[j] = g; m_last[j] = in_last[g];
`ifdef DTT_XBAR_PKT_LOCK_EN
        if (in_last[g]) begin m_lock[j] = 1'b0; m_ptr[j] = (g + 1) % NI; end
        else begin m_lock[j] = 1'b1; m_owner[j] = g; end
`else
        m_ptr[j] = (g + 1) % NI;
`endif
      end else if (out_ready[j]) begin
        m_valid[j] = 1'b0;
      end
    end
  endtask

  // One cycle: compare at the falling edge, advance model at the rising edge
  task automatic step(input bit cmp);
    @(negedge clk);
    model_arb();
    if (cmp) begin
      chk("in_ready", 64'(in_ready), 64'(m_ready));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      for (int j = 0; j < NO; j++) begin
        chk($sformatf("out_data[%0d]", j), 64'(out_data[j]), 64'(m_data[j]));
        chk($sformatf("out_src[%0d]", j), 64'(out_src[j]), 64'(m_src[j]));
        chk($sformatf("out_last[%0d]", j), 64'(out_last[j]), 64'(m_last[j]));
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NI; i++) begin
      in_data[i] = '0; in_dest[i] = '0;
    end
    in_last = '0; in_valid = '0; out_ready = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(1'b1); rst = 1'b0;
  endtask

  int rr_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    m_valid = '0; m_last = '0;
    idle();
    // Reset and idle
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'(3'b000));
    for (int j = 0; j < NO; j++) chk("rst_out_data", 64'(out_data[j]), 64'(32'h0));
    chk("idle_in_ready", 64'(in_ready), 64'(4'b0000));
    step(1'b1);

    // No contention: in0 -> out2, in1 -> out1 in the same cycle
    in_valid = 4'b0011;
    in_dest[0] = 2'd2; in_data[0] = 32'hA5A5_0001;
    in_dest[1] = 2'd1; in_data[1] = 32'h0000_BEEF;
    #1 chk("nc_in_ready", 64'(in_ready), 64'(4'b0011));
    step(1'b1);
    idle();
    chk("nc_out_valid", 64'(out_valid), 64'(3'b110));
    chk("nc_data2", 64'(out_data[2]), 64'(32'hA5A5_0001));
    chk("nc_src2", 64'(out_src[2]), 64'(2'd0));
    chk("nc_data1", 64'(out_data[1]), 64'(32'h0000_BEEF));
    chk("nc_src1", 64'(out_src[1]), 64'(2'd1));

    // Round-robin: all inputs to out1, downstream always ready
    do_reset();
    in_valid = 4'b1111;
    for (int i = 0; i < NI; i++) begin in_dest[i] = 2'd1; in_data[i] = DW'(32'h100 + i); end
    for (int c = 0; c < 8; c++) begin
      #1 chk("rr_grant", 64'(in_ready), 64'(4'b0001 << rr_order[c]));
      step(1'b1);
    end
    idle();

    // Backpressure on out0, then release without a bubble
    do_reset();
    in_valid = 4'b0001; in_dest[0] = 2'd0; in_data[0] = 32'd100;
    step(1'b1);
    out_ready[0] = 1'b0; in_data[0] = 32'd101;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_in_ready", 64'(in_ready[0]), 64'(1'b0));
      step(1'b1);
      chk("bp_hold", 64'(out_data[0]), 64'(32'd100));
    end
    out_ready[0] = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready[0]), 64'(1'b1));
    step(1'b1);
    chk("bp_refill_data", 64'(out_data[0]), 64'(32'd101));
    chk("bp_refill_valid", 64'(out_valid[0]), 64'(1'b1));
    idle();
    step(1'b1);

    // Invalid destination is consumed and dropped
    do_reset();
    in_valid = 4'b1000; in_dest[3] = 2'd3; in_data[3] = 32'hDEAD_0003;
    #1 chk("bad_dest_ready", 64'(in_ready), 64'(4'b1000));
    step(1'b1);
    chk("bad_dest_no_out", 64'(out_valid), 64'(3'b000));
    idle();

`ifdef DTT_XBAR_PKT_LOCK_EN
    // Packet lock: in2 sends 3 beats to out0 while in0 also asks for out0
    do_reset();
    in_valid = 4'b0100; in_dest[2] = 2'd0; in_data[2] = 32'h2001; in_last[2] = 1'b0;
    step(1'b1);
    in_valid = 4'b0101; in_dest[0] = 2'd0; in_data[0] = 32'h0001;
    in_data[2] = 32'h2002;
    #1 chk("lock_beat2", 64'(in_ready), 64'(4'b0100));
    step(1'b1);
    in_data[2] = 32'h2003; in_last[2] = 1'b1;
    #1 chk("lock_beat3", 64'(in_ready), 64'(4'b0100));
    step(1'b1);
    in_valid = 4'b0001; in_last[2] = 1'b0;
    #1 chk("lock_release", 64'(in_ready), 64'(4'b0001));
    step(1'b1);
    chk("lock_after_src", 64'(out_src[0]), 64'(2'd0));
    idle();
`endif

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NI; i++) begin
        in_valid[i] = $urandom_range(0, 1);
        in_dest[i]  = DSW'($urandom_range(0, 3));
        in_data[i]  = $urandom;
        in_last[i]  = ($urandom_range(0, 3) == 0);
      end
      for (int j = 0; j < NO; j++) out_ready[j] = ($urandom_range(0, 3) != 0);
      step(1'b1);
    end
    rst = 1'b0;
    idle();
    step(1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
